// File: rtl/sync_edge_filter_pkg.sv
// sync_pkg: shared types and constants for the sync_edge_filter slice.
//   filt_state_t      : glitch-filter FSM states
//   EVT_RISE/EVT_FALL : encoding of evt_dir
package sync_pkg;

  typedef enum logic [1:0] {
    S_LO,
    S_QUAL_HI,
    S_HI,
    S_QUAL_LO
  } filt_state_t;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

endpackage

// File: rtl/sync_edge_filter_if.sv
// sync_edge_filter_if: committed-edge event handshake.
//   evt_valid : event pending (held until accepted)
//   evt_dir   : direction of pending event, 1=rise 0=fall
//   evt_ready : consumer accepts event
// master = event producer (filter), slave = consumer.
interface sync_edge_filter_if;
  logic evt_valid;
  logic evt_dir;
  logic evt_ready;

  modport master (output evt_valid, output evt_dir, input evt_ready);
  modport slave  (input evt_valid, input evt_dir, output evt_ready);
endinterface

// File: rtl/sync_edge_filter_glitch_filter.sv
// glitch_filter: stability filter on a synchronized bit.
// A level change is committed only after STABLE_CYCLES consecutive samples
// at the new value; shorter excursions are discarded.
//   clk_dst, rst_dst        : clock, async active-high reset
//   sync_in                 : synchronized input bit
//   level_out               : filtered level (registered)
//   rise_pulse, fall_pulse  : one-cycle registered pulses with the level change
//   commit_rise/commit_fall : combinational strobes, high in the cycle whose
//                             edge commits; lets the parent update its own
//                             state on the same edge as level_out
module glitch_filter
  import sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk_dst,
  input  logic rst_dst,
  input  logic sync_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic commit_rise,
  output logic commit_fall
);

  if (STABLE_CYCLES < 2) begin : g_bad_param
    $error("glitch_filter: STABLE_CYCLES must be >= 2");
  end

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  filt_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // cnt counts samples already seen at the candidate level; the sample that
  // finds cnt==LAST is the STABLE_CYCLES-th and commits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    case (state_q)
      S_LO: if (sync_in) begin
        state_d = S_QUAL_HI;
        cnt_d   = CW'(1);
      end
      S_QUAL_HI: begin
        if (!sync_in) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d     = S_HI;
          cnt_d       = '0;
          commit_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: if (!sync_in) begin
        state_d = S_QUAL_LO;
        cnt_d   = CW'(1);
      end
      S_QUAL_LO: begin
        if (sync_in) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d     = S_LO;
          cnt_d       = '0;
          commit_fall = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      state_q    <= S_LO;
      cnt_q      <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rise_pulse <= commit_rise;
      fall_pulse <= commit_fall;
      if (commit_rise)      level_out <= 1'b1;
      else if (commit_fall) level_out <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_edge_filter.sv
// sync_edge_filter: filtered level/pulses plus edge bookkeeping for a
// synchronized bit in the clk_dst domain.
//   clk_dst, rst_dst  : clock, async active-high reset
//   sync_in           : synchronized input bit
//   count_clr         : sync clear of edge_count and evt_ovf
//   level_out         : filtered level
//   rise/fall_pulse   : one-cycle pulses on committed edges
//   edge_count        : saturating count of committed edges
//   evt_ovf           : sticky, an event was dropped
//   evt (master)      : evt_valid/evt_dir held until evt_ready
module sync_edge_filter
  import sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk_dst,
  input  logic             rst_dst,
  input  logic             sync_in,
  input  logic             count_clr,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             evt_ovf,
  sync_edge_filter_if.master evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic commit_rise, commit_fall, commit, hs;
  logic valid_q, dir_q;

  glitch_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk_dst     (clk_dst),
    .rst_dst     (rst_dst),
    .sync_in     (sync_in),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .commit_rise (commit_rise),
    .commit_fall (commit_fall)
  );

  assign commit        = commit_rise | commit_fall;
  assign hs            = valid_q & evt.evt_ready;
  assign evt.evt_valid = valid_q;
  assign evt.evt_dir   = dir_q;

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      edge_count <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      evt_ovf    <= 1'b0;
    end else begin
      // clear and commit together leave the new edge counted
      if (count_clr)                           edge_count <= commit ? CNT_W'(1) : '0;
      else if (commit && edge_count != CNT_MAX) edge_count <= edge_count + CNT_W'(1);

      // a slot is free if empty or being drained this edge (no bubble)
      if (commit) begin
        if (!valid_q || hs) begin
          valid_q <= 1'b1;
          dir_q   <= commit_rise ? EVT_RISE : EVT_FALL;
        end
      end else if (hs) begin
        valid_q <= 1'b0;
      end

      // drop beats clear
      if (commit && valid_q && !evt.evt_ready) evt_ovf <= 1'b1;
      else if (count_clr)                      evt_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_edge_filter.sv
module tb_sync_edge_filter;
  import sync_pkg::*;

  localparam int S  = 4;
  localparam int CW = 4;

  logic          clk_dst = 1'b0;
  logic          rst_dst = 1'b1;
  logic          sync_in = 1'b0;
  logic          count_clr = 1'b0;
  logic          level_out, rise_pulse, fall_pulse, evt_ovf;
  logic [CW-1:0] edge_count;

  sync_edge_filter_if evt();

  sync_edge_filter #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk_dst    (clk_dst),
    .rst_dst    (rst_dst),
    .sync_in    (sync_in),
    .count_clr  (count_clr),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_count (edge_count),
    .evt_ovf    (evt_ovf),
    .evt        (evt)
  );

  always #5 clk_dst = ~clk_dst;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a level changes once the last S samples since the
  // previous change all disagree with it
  bit     hist[$];
  bit     m_level, m_rise, m_fall, m_vld, m_dir, m_ovf;
  int     m_count;

  task automatic model_reset();
    hist.delete();
    m_level = 0; m_rise = 0; m_fall = 0;
    m_vld = 0; m_dir = 0; m_ovf = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit commit, dir, all_diff, hs, drop;
    commit = 0; dir = 0; drop = 0;
    hist.push_back(sync_in);
    if (hist.size() > S) void'(hist.pop_front());
    m_rise = 0; m_fall = 0;
    all_diff = (hist.size() == S);
    foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
    if (all_diff) begin
      commit  = 1;
      m_level = !m_level;
      dir     = m_level;
      m_rise  = m_level;
      m_fall  = !m_level;
      hist.delete();
    end
    hs = m_vld && evt.evt_ready;
    if (commit) begin
      if (!m_vld || hs) begin m_vld = 1; m_dir = dir; end
      else drop = 1;
    end else if (hs) m_vld = 0;
    if (drop) m_ovf = 1;
    else if (count_clr) m_ovf = 0;
    if (count_clr) m_count = commit;
    else if (commit && m_count < (1 << CW) - 1) m_count++;
  endtask

  task automatic check_all();
    chk("level", level_out, m_level);
    chk("rise",  rise_pulse, m_rise);
    chk("fall",  fall_pulse, m_fall);
    chk("count", edge_count, m_count);
    chk("valid", evt.evt_valid, m_vld);
    if (m_vld) chk("dir", evt.evt_dir, m_dir);
    chk("ovf",   evt_ovf, m_ovf);
  endtask

  task automatic step();
    @(posedge clk_dst);
    model_edge();
    @(negedge clk_dst);
    check_all();
  endtask

  task automatic drive(input bit v, input int n);
    sync_in = v;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    evt.evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_dst);
    check_all();
    rst_dst = 1'b0;

    // first rise: latency S edges of sampling
    sync_in = 1;
    repeat (S - 1) step();
    chk("rise_early", level_out, 0);
    step();
    chk("rise_lvl", level_out, 1);
    chk("rise_pls", rise_pulse, 1);
    step();
    chk("rise_pls_w", rise_pulse, 0);
    chk("rise_cnt", edge_count, 1);
    chk("rise_dir", evt.evt_dir, EVT_RISE);

    // low glitch shorter than S, then a fall dropped while ready=0
    drive(0, S - 1);
    drive(1, 3);
    chk("glitch_lvl", level_out, 1);
    chk("glitch_cnt", edge_count, 1);
    drive(0, S + 2);
    chk("drop_ovf", evt_ovf, 1);
    chk("drop_dir", evt.evt_dir, EVT_RISE);
    evt.evt_ready = 1; step();
    chk("hs_vld", evt.evt_valid, 0);
    count_clr = 1; step(); count_clr = 0;
    chk("clr_ovf", evt_ovf, 0);
    chk("clr_cnt", edge_count, 0);

    // square wave, ready tied high
    for (int p = 0; p < 5; p++) begin drive(1, 5); drive(0, 5); end
    chk("sq_cnt", edge_count, 10);
    chk("sq_ovf", evt_ovf, 0);

    // saturation
    count_clr = 1; step(); count_clr = 0;
    for (int p = 0; p < 10; p++) begin drive(1, 5); drive(0, 5); end
    chk("sat_cnt", edge_count, 15);
    sync_in = 1;
    repeat (S - 1) step();
    count_clr = 1; step(); count_clr = 0;
    chk("clr_commit", edge_count, 1);
    drive(0, 6);

    // randomized runs
    for (int k = 0; k < 250; k++) begin
      sync_in = 1'($urandom_range(0, 1));
      for (int j = $urandom_range(1, 7); j > 0; j--) begin
        evt.evt_ready = ($urandom_range(0, 3) != 0);
        count_clr     = ($urandom_range(0, 31) == 0);
        step();
      end
    end
    count_clr = 0;

    // async reset mid-qualification with an event pending
    evt.evt_ready = 0;
    drive(0, 6); drive(1, 4); drive(0, 4); drive(1, 2);
    chk("pre_rst_vld", evt.evt_valid, 1);
    #2 rst_dst = 1;
    #1;
    chk("arst_lvl",  level_out, 0);
    chk("arst_vld",  evt.evt_valid, 0);
    chk("arst_cnt",  edge_count, 0);
    chk("arst_ovf",  evt_ovf, 0);
    chk("arst_dir",  evt.evt_dir, 0);
    chk("arst_pls",  {rise_pulse, fall_pulse}, 0);
    @(negedge clk_dst);
    rst_dst = 0;
    model_reset();
    sync_in = 1;
    repeat (S - 1) step();
    chk("rst_rise_early", level_out, 0);
    step();
    chk("rst_rise", level_out, 1);
    chk("rst_rise_pls", rise_pulse, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_edge_filter.md
Name: sync_edge_filter

Overview:
- Downstream consumer of the dual-FF synchronizer output in the clk_dst domain.
- Applies a stability filter to the synchronized bit and rejects pulses shorter than STABLE_CYCLES.
- Emits a clean level and one-cycle rise/fall pulses.
- Keeps a saturating edge counter and presents each committed edge as a held valid/ready event with a sticky overflow flag.

Parameters:
- STABLE_CYCLES, 4, consecutive equal samples required to commit a level change; must be >=2 (elaboration-time check).
- CNT_W, 16, width of edge_count.

Ports:
- clk_dst  in  1  destination-domain clock
- rst_dst  in  1  reset, asynchronous, active-high
- sync_in  in  1  synchronized single-bit input from the synchronizer stage
- count_clr  in  1  synchronous clear of edge_count and evt_ovf
- level_out  out  1  filtered level
- rise_pulse  out  1  one-cycle pulse on committed 0->1
- fall_pulse  out  1  one-cycle pulse on committed 1->0
- edge_count  out  CNT_W  committed edges since reset/clear, saturating
- evt_valid  out  1  event pending
- evt_dir  out  1  direction of pending event: 1=rise, 0=fall
- evt_ready  in  1  consumer accepts event
- evt_ovf  out  1  sticky: an event was dropped

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=S_LO, stab_cnt=0, and every output is 0.
- Reset mid-qualification discards progress; a high sync_in after reset is qualified as a normal rise.
- FSM states: S_LO, S_QUAL_HI, S_HI, S_QUAL_LO.
- S_LO: sync_in=1 -> S_QUAL_HI, stab_cnt=1; else stay.
- S_QUAL_HI:
  - sync_in=0 -> S_LO, stab_cnt=0 (glitch rejected, no pulse, no count).
  - sync_in=1 and stab_cnt==STABLE_CYCLES-1 -> commit rise: S_HI, level_out<=1, rise_pulse<=1.
  - sync_in=1 otherwise -> stab_cnt++.
- S_HI / S_QUAL_LO: mirror of the above with sync_in=0, committing a fall (level_out<=0, fall_pulse<=1).
- Latency: if sync_in is first sampled high at edge t0 and stays high, level_out and rise_pulse are 1 after edge t0+STABLE_CYCLES-1.
- Pulses are registered, exactly one cycle wide and coincident with the level_out change.
- Minimum spacing between commits is STABLE_CYCLES cycles.
- edge_count:
  - +1 on each commit; holds at 2^CNT_W-1 (no wrap).
  - count_clr alone -> 0.
  - count_clr coincident with a commit -> 1.
- Event register:
  - Handshake occurs on evt_valid && evt_ready; evt_valid and evt_dir are held stable until then.
  - Commit with evt_valid=0 -> evt_valid<=1, evt_dir<=direction.
  - Commit coincident with a handshake -> new event loaded, evt_valid stays 1 (no bubble).
  - Handshake without a commit -> evt_valid<=0.
  - Commit while evt_valid=1 and evt_ready=0 -> new event dropped, held event unchanged, evt_ovf<=1.
- evt_ovf: cleared by count_clr; a drop in the same cycle as count_clr leaves evt_ovf=1 (set wins).
- count_clr does not affect FSM, level_out or the event register.

Decomposition:
- Shared package sync_pkg:
  - filt_state_t enum {S_LO, S_QUAL_HI, S_HI, S_QUAL_LO}.
  - constants EVT_RISE=1'b1, EVT_FALL=1'b0.
- Sub-module glitch_filter (params STABLE_CYCLES):
  - Contains the FSM and stab_cnt.
  - Outputs level_out, rise_pulse, fall_pulse.
- Top level sync_edge_filter adds edge_count, the event register and evt_ovf.

Test Plan:
- Reset, then sync_in=1 held (STABLE_CYCLES=4) -> level_out=0 for 3 edges, then 1 after 4th sampling edge; rise_pulse high exactly 1 cycle; edge_count=1; evt_valid=1, evt_dir=1.
- sync_in high for 3 cycles then low (glitch) -> no level change, no pulses, edge_count unchanged, evt_valid unchanged.
- evt_ready tied 1, square wave period 10 on sync_in for 5 periods -> 10 alternating rise/fall events each accepted the cycle after commit; evt_ovf=0; edge_count=10.
- evt_ready=0, drive rise then fall -> first event held (evt_dir=1), fall dropped, evt_ovf=1; evt_ready=1 -> handshake, evt_valid=0; count_clr -> evt_ovf=0, edge_count=0.
- CNT_W=4, drive 20 committed edges -> edge_count saturates at 15; count_clr on the same cycle as a commit -> edge_count=1.
- Assert rst_dst asynchronously mid-S_QUAL_HI with evt_valid=1 -> all outputs 0 immediately; on release with sync_in=1 -> rise committed STABLE_CYCLES-1 edges after the first sampling edge.
